// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and default latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5,
    OpMadd  = 3'd6,
    OpMaddu = 3'd7
  } mdu_op_e;

  localparam int unsigned DefMultCycles = 5;
  localparam int unsigned DefDivCycles  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result for a timed op. Multiply-accumulate paths exist only
// when MDU_MADD_EN is defined; otherwise ops 6/7 pass HI/LO through unchanged.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0]      prod_s, prod_u;
  logic                    div_zero, div_ovf;
  logic [WIDTH-1:0]        b_sdiv, b_udiv;
  logic signed [WIDTH-1:0] quot_s, rem_s;
  logic [WIDTH-1:0]        quot_u, rem_u;

  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign div_zero = (b == '0);
  assign div_ovf  = (a == MostNeg) && (b == '1);

  // Dividing most-negative by 1 yields exactly the overflow result (q = a, r = 0).
  assign b_sdiv = (div_zero || div_ovf) ? One : b;
  assign b_udiv = div_zero ? One : b;

  assign quot_s = $signed(a) / $signed(b_sdiv);
  assign rem_s  = $signed(a) % $signed(b_sdiv);
  assign quot_u = a / b_udiv;
  assign rem_u  = a % b_udiv;

  always_comb begin
    next_hi = hi;
    next_lo = lo;
    case (op)
      OpMult:  {next_hi, next_lo} = prod_s;
      OpMultu: {next_hi, next_lo} = prod_u;
      OpDiv: begin
        next_lo = div_zero ? '1 : quot_s;
        next_hi = div_zero ? a  : rem_s;
      end
      OpDivu: begin
        next_lo = div_zero ? '1 : quot_u;
        next_hi = div_zero ? a  : rem_u;
      end
`ifdef MDU_MADD_EN
      OpMadd:  {next_hi, next_lo} = {hi, lo} + prod_s;
      OpMaddu: {next_hi, next_lo} = {hi, lo} + prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: IDLE/RUN FSM, cycle counter and HI/LO registers.
// Define MDU_MADD_EN to enable MADD/MADDU (ops 6/7) as timed multiply-accumulate ops.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = DefMultCycles,
  parameter int unsigned DIV_CYCLES  = DefDivCycles
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, a_q, b_q;
  mdu_op_e          op_q;
  logic             busy_q, done_q;

  mdu_op_e          start_op;
  logic             start_timed;
  logic [CntW-1:0]  start_cnt;
  logic [WIDTH-1:0] next_hi, next_lo;

  always_comb begin
    start_op    = mdu_op_e'(op);
    start_timed = 1'b0;
    start_cnt   = '0;
    case (start_op)
      OpMult, OpMultu: begin
        start_timed = 1'b1;
        start_cnt   = CntW'(MULT_CYCLES - 1);
      end
      OpDiv, OpDivu: begin
        start_timed = 1'b1;
        start_cnt   = CntW'(DIV_CYCLES - 1);
      end
`ifdef MDU_MADD_EN
      OpMadd, OpMaddu: begin
        start_timed = 1'b1;
        start_cnt   = CntW'(MULT_CYCLES - 1);
      end
`endif
      default: ;
    endcase
  end

  // HI/LO cannot change during RUN, so the live registers equal their value at E0.
  mdu_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .hi      (hi_q),
    .lo      (lo_q),
    .next_hi (next_hi),
    .next_lo (next_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OpMult;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (start_timed) begin
              a_q     <= a;
              b_q     <= b;
              op_q    <= start_op;
              cnt_q   <= start_cnt;
              state_q <= StRun;
              busy_q  <= 1'b1;
            end else if (start_op == OpMthi) begin
              hi_q <= a;
            end else if (start_op == OpMtlo) begin
              lo_q <= a;
            end
          end
        end
        StRun: begin
          if (cnt_q == '0) begin
            hi_q    <= next_hi;
            lo_q    <= next_lo;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and HI/LO width.
REQ-002 SHALL have parameter MULT_CYCLES, default 5: busy cycles for multiply ops (legal >= 1).
REQ-003 SHALL have parameter DIV_CYCLES, default 10: busy cycles for divide ops (legal >= 1).
REQ-004 SHALL have port clk  input  1: sole clock, rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port start  input  1: request to execute op this cycle.
REQ-007 SHALL have port op  input  3: operation code.
REQ-008 SHALL have port a  input  WIDTH: operand A (rs value).
REQ-009 SHALL have port b  input  WIDTH: operand B (rt value).
REQ-010 SHALL have port busy  output  1: operation in flight; new starts ignored.
REQ-011 SHALL have port done  output  1: one-cycle pulse after HI/LO update by a timed op.
REQ-012 SHALL have port hi  output  WIDTH: HI register.
REQ-013 SHALL have port lo  output  WIDTH: LO register.

Function
REQ-014 SHALL use op codes: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
REQ-015 SHALL implement FSM IDLE/RUN; start only accepted in IDLE (busy=0).
REQ-016 SHALL, on accepted timed op (0-3, plus 6-7 when enabled) at edge E0, latch a, b, op and go to RUN with busy=1 after E0.
REQ-017 SHALL hold busy=1 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), write HI/LO at edge E0+N, then return to IDLE with busy=0.
REQ-018 SHALL pulse done=1 for the single cycle following the HI/LO update edge.
REQ-019 SHALL keep hi/lo at previous values throughout RUN; operand changes after E0 have no effect.
REQ-020 SHALL, for MTHI/MTLO accepted in IDLE, write a into hi/lo at the same edge, with no busy and no done.
REQ-021 SHALL ignore start while busy=1 (no queueing, no state change).
REQ-022 SHALL compute MULT/MULTU as signed/unsigned 2*WIDTH product, {hi,lo} = product.
REQ-023 SHALL compute DIV/DIVU with lo=quotient truncated toward zero, hi=remainder carrying dividend sign.
REQ-024 SHALL, on divide by zero, still take DIV_CYCLES, then set lo=all ones, hi=a.
REQ-025 SHALL, on signed DIV of most-negative by -1, set lo=most-negative, hi=0.

Reset
REQ-026 SHALL, on reset=1 at an edge, set hi=0, lo=0, busy=0, done=0, state IDLE, aborting any op in flight.
REQ-027 SHALL give reset priority over a simultaneous start.

Configuration
REQ-028 SHALL, with macro MDU_MADD_EN defined, implement MADD/MADDU as timed ops of MULT_CYCLES: {hi,lo} += signed/unsigned product of latched a,b and the {hi,lo} value at E0, modulo 2^(2*WIDTH).
REQ-029 SHALL, without MDU_MADD_EN, treat op 6/7 as ignored: no busy, no done, no state change.

Structure
REQ-030 SHALL place op encodings and default cycle counts in shared package mdu_pkg.
REQ-031 SHALL split result arithmetic into combinational sub-module mdu_arith (latched operands, op, {hi,lo} at E0 -> next {hi,lo}); the FSM, cycle counter and HI/LO registers stay in mult_div_unit.

Verification
REQ-032 SHALL cover: MULT a=-3 b=7 -> busy 5 cycles, then hi=FFFFFFFF, lo=FFFFFFEB, done pulse 1 cycle.
REQ-033 SHALL cover: DIV a=-7 b=2 -> busy 10 cycles, then lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=7 b=0 -> lo=FFFFFFFF, hi=7.
REQ-034 SHALL cover: MULTU a=FFFFFFFF b=2 with MTLO start on cycle 2 of busy -> MTLO ignored; hi=1, lo=FFFFFFFE.
REQ-035 SHALL cover: MTHI a=12345678 in IDLE -> hi=12345678 next cycle, busy stays 0, done stays 0.
REQ-036 SHALL cover: reset asserted on cycle 3 of DIV -> next cycle busy=0, hi=lo=0, no done; start with reset same edge -> ignored.
REQ-037 SHALL cover, with MDU_MADD_EN: hi=0 lo=FFFFFFFF, MADDU a=1 b=1 -> hi=1, lo=0 after 5 cycles; without the macro, op 7 -> no change, busy 0.
